par_serializer: RTL and testbench

Parametrised parallel-to-serial converter for the UART transmit path, the successor to the fixed 8-bit serializer. It accepts words through a valid/ready handshake into a one-entry holding buffer, so back-to-back frames leave no idle gap. Frame length (1..DATA_WIDTH) and bit order are selectable per word, and the frame's parity is computed at load. It sits between the TX data source and the TX frame FSM/output mux; the FSM advances it with `ser_en`.

---
 rtl/par_serializer_if.sv | 46 ++++
 rtl/par_serializer.sv | 197 +++++++++++++++++++
 tb/tb_par_serializer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/par_serializer_if.sv
// -----------------------------------------------------------------------------
// par_serializer_if
// Bundles the word-side handshake and the serial-side strobe/outputs of the
// parallel-to-serial converter.
//   P_DATA      word offered by the TX data source
//   Data_Valid  word on P_DATA is valid
//   ready       converter can take a word this cycle
//   frame_len   bits to send (0 or > DATA_WIDTH means DATA_WIDTH)
//   msb_first   1 = MSB first, 0 = LSB first
//   par_odd     0 = even parity, 1 = odd parity
//   ser_en      shift strobe from the TX frame FSM
//   ser_data    current serial bit (mark when idle)
//   ser_last    current bit is the last one of the frame
//   ser_done    one-cycle pulse after the last bit is consumed
//   par_bit     parity of the active frame
//   busy        shift register active or holding buffer full
// master = data source / TX FSM side, slave = converter.
// -----------------------------------------------------------------------------
interface par_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int LEN_W = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  ready;
  logic [LEN_W-1:0]      frame_len;
  logic                  msb_first;
  logic                  par_odd;
  logic                  ser_en;
  logic                  ser_data;
  logic                  ser_last;
  logic                  ser_done;
  logic                  par_bit;
  logic                  busy;

  modport master (
    output P_DATA, Data_Valid, frame_len, msb_first, par_odd, ser_en,
    input  ready, ser_data, ser_last, ser_done, par_bit, busy
  );

  modport slave (
    input  P_DATA, Data_Valid, frame_len, msb_first, par_odd, ser_en,
    output ready, ser_data, ser_last, ser_done, par_bit, busy
  );
endinterface

// File: rtl/par_serializer.sv
// -----------------------------------------------------------------------------
// par_serializer
// Parameterised parallel-to-serial converter for the UART transmit path.
// Words arrive through a valid/ready handshake into a one-entry holding
// buffer so consecutive frames leave the line with no idle gap. Frame length
// and bit order are chosen per word; the frame parity is computed at accept.
// Ports:
//   CLK  clock, rising edge
//   RST  asynchronous active-high reset
//   bus  par_serializer_if.slave (handshake, strobe and serial outputs)
// -----------------------------------------------------------------------------
module par_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic              CLK,
  input  logic              RST,
  par_serializer_if.slave   bus
);
  localparam int LEN_W = $clog2(DATA_WIDTH + 1);
  localparam int IDX_W = $clog2(DATA_WIDTH);

  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

  // Clamp the requested length: 0 or anything above DATA_WIDTH sends a full word.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    if ((len == {LEN_W{1'b0}}) || (len > LEN_W'(DATA_WIDTH))) begin
      return LEN_W'(DATA_WIDTH);
    end else begin
      return len;
    end
  endfunction

  // Rearrange the word so the frame always leaves from bit 0 upward; bits
  // beyond the frame length are zeroed so they cannot affect parity.
  function automatic logic [DATA_WIDTH-1:0] order_bits(input logic [DATA_WIDTH-1:0] w,
                                                       input logic [LEN_W-1:0] len,
                                                       input logic msb);
    logic [DATA_WIDTH-1:0] o;
    o = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < int'(len)) begin
        if (msb) begin
          o[IDX_W'(i)] = w[IDX_W'(int'(len) - 1 - i)];
        end else begin
          o[IDX_W'(i)] = w[IDX_W'(i)];
        end
      end else begin
        o[IDX_W'(i)] = 1'b0;
      end
    end
    return o;
  endfunction

  // Frame parity: XOR of the transmitted bits, inverted for odd parity.
  function automatic logic frame_parity(input logic [DATA_WIDTH-1:0] bits, input logic odd);
    return (^bits) ^ odd;
  endfunction

  state_t                state_r, state_nx_s;
  logic [DATA_WIDTH-1:0] shift_r, shift_nx_s;
  logic [LEN_W-1:0]      cnt_r, cnt_nx_s;
  logic [LEN_W-1:0]      len_r, len_nx_s;
  logic                  par_bit_r, par_nx_s;
  logic                  ser_done_r, done_nx_s;
  logic                  ser_data_r, ser_data_nx_s;
  logic                  busy_r, busy_nx_s;
  logic                  ready_r, ready_nx_s;
  logic                  hold_valid_r, hold_valid_nx_s;
  logic [DATA_WIDTH-1:0] hold_word_r, hold_word_nx_s;
  logic [LEN_W-1:0]      hold_len_r, hold_len_nx_s;
  logic                  hold_par_r, hold_par_nx_s;

  logic [LEN_W-1:0]      in_len_s;
  logic [DATA_WIDTH-1:0] in_bits_s;
  logic                  in_par_s;
  logic                  accept_s;
  logic                  last_s;

  assign in_len_s  = eff_len(bus.frame_len);
  assign in_bits_s = order_bits(bus.P_DATA, in_len_s, bus.msb_first);
  assign in_par_s  = frame_parity(in_bits_s, bus.par_odd);
  assign accept_s  = bus.Data_Valid && !hold_valid_r;
  assign last_s    = (state_r == ST_SHIFT) && (cnt_r == (len_r - LEN_W'(1)));

  // Next-state: frame sequencing, holding-buffer fill/transfer and output values.
  always_comb begin
    state_nx_s      = state_r;
    shift_nx_s      = shift_r;
    cnt_nx_s        = cnt_r;
    len_nx_s        = len_r;
    par_nx_s        = par_bit_r;
    done_nx_s       = 1'b0;
    hold_valid_nx_s = hold_valid_r;
    hold_word_nx_s  = hold_word_r;
    hold_len_nx_s   = hold_len_r;
    hold_par_nx_s   = hold_par_r;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nx_s = ST_SHIFT;
          shift_nx_s = in_bits_s;
          len_nx_s   = in_len_s;
          par_nx_s   = in_par_s;
          cnt_nx_s   = {LEN_W{1'b0}};
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bus.ser_en && last_s) begin
          done_nx_s = 1'b1;
          if (hold_valid_r) begin
            // Held word takes over on the same edge: no gap on the line.
            shift_nx_s      = hold_word_r;
            len_nx_s        = hold_len_r;
            par_nx_s        = hold_par_r;
            cnt_nx_s        = {LEN_W{1'b0}};
            hold_valid_nx_s = 1'b0;
          end else if (accept_s) begin
            shift_nx_s = in_bits_s;
            len_nx_s   = in_len_s;
            par_nx_s   = in_par_s;
            cnt_nx_s   = {LEN_W{1'b0}};
          end else begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = {LEN_W{1'b0}};
          end
        end else begin
          if (bus.ser_en) begin
            shift_nx_s = {1'b0, shift_r[DATA_WIDTH-1:1]};
            cnt_nx_s   = cnt_r + LEN_W'(1);
          end else begin
            shift_nx_s = shift_r;
          end
          if (accept_s) begin
            hold_valid_nx_s = 1'b1;
            hold_word_nx_s  = in_bits_s;
            hold_len_nx_s   = in_len_s;
            hold_par_nx_s   = in_par_s;
          end else begin
            hold_valid_nx_s = hold_valid_r;
          end
        end
      end
      default: begin
        state_nx_s      = ST_IDLE;
        hold_valid_nx_s = 1'b0;
        cnt_nx_s        = {LEN_W{1'b0}};
      end
    endcase

    ser_data_nx_s = (state_nx_s == ST_SHIFT) ? shift_nx_s[0] : 1'b1;
    busy_nx_s     = (state_nx_s == ST_SHIFT) || hold_valid_nx_s;
    ready_nx_s    = !hold_valid_nx_s;
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      shift_r      <= {DATA_WIDTH{1'b0}};
      cnt_r        <= {LEN_W{1'b0}};
      len_r        <= {LEN_W{1'b0}};
      par_bit_r    <= 1'b0;
      ser_done_r   <= 1'b0;
      ser_data_r   <= 1'b1;
      busy_r       <= 1'b0;
      ready_r      <= 1'b1;
      hold_valid_r <= 1'b0;
      hold_word_r  <= {DATA_WIDTH{1'b0}};
      hold_len_r   <= {LEN_W{1'b0}};
      hold_par_r   <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      shift_r      <= shift_nx_s;
      cnt_r        <= cnt_nx_s;
      len_r        <= len_nx_s;
      par_bit_r    <= par_nx_s;
      ser_done_r   <= done_nx_s;
      ser_data_r   <= ser_data_nx_s;
      busy_r       <= busy_nx_s;
      ready_r      <= ready_nx_s;
      hold_valid_r <= hold_valid_nx_s;
      hold_word_r  <= hold_word_nx_s;
      hold_len_r   <= hold_len_nx_s;
      hold_par_r   <= hold_par_nx_s;
    end
  end

  assign bus.ser_data = ser_data_r;
  assign bus.ser_last = last_s;
  assign bus.ser_done = ser_done_r;
  assign bus.par_bit  = par_bit_r;
  assign bus.busy     = busy_r;
  assign bus.ready    = ready_r;
endmodule

// File: tb/tb_par_serializer.sv
// -----------------------------------------------------------------------------
// tb_par_serializer
// Self-checking bench: a vector table of single frames, hand-written
// back-to-back / simultaneous-load / reset sequences, and randomized traffic.
// A queue-based model of the frame behaviour is compared every cycle.
// -----------------------------------------------------------------------------
module tb_par_serializer;
  localparam int DW = 8;

  logic CLK;
  logic RST;

  par_serializer_if #(.DATA_WIDTH(DW)) bus ();

  par_serializer #(.DATA_WIDTH(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state: bits still to send, held frame, parity, done pulse.
  bit cur_q[$];
  bit hold_q[$];
  bit hold_v;
  bit hold_par;
  bit m_par;
  bit m_done;
  bit nf_q[$];
  bit nf_par;

  typedef struct {
    logic [7:0] data;
    logic [3:0] len;
    logic       msb;
    logic       podd;
    int         elen;
    logic [7:0] eseq;   // eseq[i] = i-th bit on the line
    logic       epar;
    int         gap;    // cycles between strobes
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    cur_q  = {};
    hold_q = {};
    hold_v = 1'b0;
    hold_par = 1'b0;
    m_par  = 1'b0;
    m_done = 1'b0;
  endtask

  // Frame bits straight from the rules: clamp length, pick index order, parity by popcount.
  task automatic build(input logic [7:0] d, input logic [3:0] len, input logic msb, input logic podd);
    int l;
    int ones;
    l = (len == 4'd0 || int'(len) > DW) ? DW : int'(len);
    nf_q = {};
    for (int i = 0; i < l; i++) begin
      nf_q.push_back(msb ? d[l-1-i] : d[i]);
    end
    ones = $countones(d & 8'((1 << l) - 1));
    nf_par = podd ^ (ones % 2 == 1);
  endtask

  task automatic model_step();
    bit accept;
    bit ending;
    if (RST) begin
      model_reset();
      return;
    end
    accept = bus.Data_Valid && !hold_v;
    if (accept) build(bus.P_DATA, bus.frame_len, bus.msb_first, bus.par_odd);
    ending = bus.ser_en && (cur_q.size() == 1);
    if (bus.ser_en && cur_q.size() > 0) void'(cur_q.pop_front());
    m_done = ending;
    if (ending && hold_v) begin
      cur_q  = hold_q;
      m_par  = hold_par;
      hold_v = 1'b0;
    end else if (accept) begin
      if (cur_q.size() == 0) begin
        cur_q = nf_q;
        m_par = nf_par;
      end else begin
        hold_q   = nf_q;
        hold_par = nf_par;
        hold_v   = 1'b1;
      end
    end
  endtask

  task automatic compare_model();
    check("m_ser_data", bus.ser_data, (cur_q.size() > 0) ? cur_q[0] : 1'b1);
    check("m_ser_last", bus.ser_last, cur_q.size() == 1);
    check("m_ser_done", bus.ser_done, m_done);
    check("m_par_bit",  bus.par_bit,  m_par);
    check("m_ready",    bus.ready,    !hold_v);
    check("m_busy",     bus.busy,     (cur_q.size() > 0) || hold_v);
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    compare_model();
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.Data_Valid = 1'b0;
    bus.ser_en = 1'b1;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
    check("drain_idle", bus.busy, 1'b0);
    bus.ser_en = 1'b0;
  endtask

  task automatic offer(input logic [7:0] d, input logic [3:0] len, input logic msb, input logic podd);
    bus.P_DATA = d;
    bus.frame_len = len;
    bus.msb_first = msb;
    bus.par_odd = podd;
    bus.Data_Valid = 1'b1;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 4'd8,  1'b0, 1'b0, 8, 8'hA5, 1'b0, 1};
    vecs[1] = '{8'hF3, 4'd5,  1'b1, 1'b0, 5, 8'h19, 1'b1, 1};
    vecs[2] = '{8'h80, 4'd0,  1'b0, 1'b0, 8, 8'h80, 1'b1, 3};
    vecs[3] = '{8'h3C, 4'd1,  1'b1, 1'b1, 1, 8'h00, 1'b1, 2};
    vecs[4] = '{8'h6B, 4'd3,  1'b0, 1'b0, 3, 8'h03, 1'b0, 1};
    vecs[5] = '{8'h5A, 4'd12, 1'b1, 1'b0, 8, 8'h5A, 1'b0, 2};

    RST = 1'b1;
    bus.P_DATA = 8'h00;
    bus.Data_Valid = 1'b0;
    bus.frame_len = 4'd0;
    bus.msb_first = 1'b0;
    bus.par_odd = 1'b0;
    bus.ser_en = 1'b0;
    model_reset();
    tick();
    tick();
    check("rst_ser_data", bus.ser_data, 1'b1);
    check("rst_ready",    bus.ready,    1'b1);
    check("rst_busy",     bus.busy,     1'b0);
    check("rst_done",     bus.ser_done, 1'b0);
    check("rst_last",     bus.ser_last, 1'b0);
    check("rst_par",      bus.par_bit,  1'b0);
    RST = 1'b0;
    tick();

    // Single frames from the vector table.
    for (int v = 0; v < 6; v++) begin
      offer(vecs[v].data, vecs[v].len, vecs[v].msb, vecs[v].podd);
      bus.ser_en = 1'b0;
      tick();
      bus.Data_Valid = 1'b0;
      check("tv_par", bus.par_bit, vecs[v].epar);
      for (int i = 0; i < vecs[v].elen; i++) begin
        check("tv_data", bus.ser_data, vecs[v].eseq[3'(i)]);
        check("tv_last", bus.ser_last, i == vecs[v].elen - 1);
        check("tv_nodone", bus.ser_done, 1'b0);
        bus.ser_en = 1'b1;
        tick();
        bus.ser_en = 1'b0;
        if (i < vecs[v].elen - 1) begin
          for (int g = 1; g < vecs[v].gap; g++) begin
            check("tv_hold", bus.ser_data, vecs[v].eseq[3'(i + 1)]);
            tick();
          end
        end
      end
      check("tv_done", bus.ser_done, 1'b1);
      check("tv_mark", bus.ser_data, 1'b1);
      check("tv_busy", bus.busy, 1'b0);
      tick();
      check("tv_done_clr", bus.ser_done, 1'b0);
    end

    // Strobes while idle are ignored.
    bus.ser_en = 1'b1;
    tick();
    tick();
    bus.ser_en = 1'b0;
    check("idle_en_data", bus.ser_data, 1'b1);
    check("idle_en_done", bus.ser_done, 1'b0);
    check("idle_en_par",  bus.par_bit,  1'b0);

    // Back-to-back: 0x01 active, 0xFF held, 0x55 stalls then gets held.
    offer(8'h01, 4'd8, 1'b0, 1'b0);
    tick();
    offer(8'hFF, 4'd8, 1'b0, 1'b0);
    tick();
    check("b2b_ready_lo", bus.ready, 1'b0);
    check("b2b_busy", bus.busy, 1'b1);
    offer(8'h55, 4'd8, 1'b0, 1'b0);
    bus.ser_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("b2b_data", bus.ser_data, (i < 8) ? (i == 0) : 1'b1);
      if (i == 8) begin
        check("b2b_done", bus.ser_done, 1'b1);
        check("b2b_ready_hi", bus.ready, 1'b1);
        check("b2b_last", bus.ser_last, 1'b0);
      end
      if (i == 9) begin
        check("b2b_held55", bus.ready, 1'b0);
        bus.Data_Valid = 1'b0;
      end
      tick();
    end
    check("b2b_55_first", bus.ser_data, 1'b1);
    drain();

    // Simultaneous: new word on the same edge as the last strobe, holding empty.
    offer(8'h0F, 4'd4, 1'b0, 1'b0);
    tick();
    bus.Data_Valid = 1'b0;
    bus.ser_en = 1'b1;
    tick();
    tick();
    tick();
    check("sim_last", bus.ser_last, 1'b1);
    offer(8'hC3, 4'd8, 1'b1, 1'b1);
    tick();
    bus.Data_Valid = 1'b0;
    bus.ser_en = 1'b0;
    check("sim_done",  bus.ser_done, 1'b1);
    check("sim_first", bus.ser_data, 1'b1);
    check("sim_busy",  bus.busy, 1'b1);
    check("sim_ready", bus.ready, 1'b1);
    check("sim_par",   bus.par_bit, 1'b1);
    drain();

    // Reset mid-frame with the holding buffer full.
    offer(8'hA7, 4'd8, 1'b0, 1'b0);
    tick();
    offer(8'h12, 4'd8, 1'b0, 1'b0);
    tick();
    bus.Data_Valid = 1'b0;
    bus.ser_en = 1'b1;
    tick();
    tick();
    check("pre_rst_par", bus.par_bit, 1'b1);
    RST = 1'b1;
    model_reset();
    #1;
    check("mrst_ser_data", bus.ser_data, 1'b1);
    check("mrst_ready",    bus.ready,    1'b1);
    check("mrst_busy",     bus.busy,     1'b0);
    check("mrst_done",     bus.ser_done, 1'b0);
    check("mrst_last",     bus.ser_last, 1'b0);
    check("mrst_par",      bus.par_bit,  1'b0);
    tick();
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_rst_nodone", bus.ser_done, 1'b0);
      check("post_rst_ready",  bus.ready, 1'b1);
    end
    bus.ser_en = 1'b0;

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      RST = ($urandom_range(0, 499) == 0);
      bus.Data_Valid = ($urandom_range(0, 1) == 1);
      bus.P_DATA = 8'($urandom);
      bus.frame_len = 4'($urandom_range(0, 15));
      bus.msb_first = 1'($urandom);
      bus.par_odd = 1'($urandom);
      bus.ser_en = ($urandom_range(0, 9) < 7);
      tick();
    end
    RST = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
